// File: rtl/gate_response_checker.sv
// Stimulus/response checker for a two-input gate: sweeps {B,A}, samples Y, tallies mismatches.
// Optional macro XZ_CHECK_EN: treat x/z on Y as a mismatch and report it on XZ_SEEN.
module gate_response_checker #(
    parameter int          DIV        = 4,
    parameter int          SETTLE     = 2,
    parameter logic [3:0]  FUNC       = 4'b0001,
    parameter int          NUM_PASSES = 1,
    parameter int          ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             Y,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [1:0]       FIRST_ERR_VEC,
    output logic             XZ_SEEN
);

    localparam int STEP_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(DIV - 1);
    localparam logic [STEP_W-1:0] SAMPLE_STEP = STEP_W'(SETTLE - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [STEP_W-1:0]  step_reg, step_next;
    logic [PASS_W-1:0]  pass_reg, pass_next;
    logic [1:0]         vec_reg, vec_next;
    logic [ERR_W-1:0]   err_reg, err_next;
    logic               fail_reg, fail_next;
    logic [1:0]         fvec_reg, fvec_next;
    logic               xz_reg, xz_next;
    logic               mismatch;
    logic               y_unknown;

`ifdef XZ_CHECK_EN
    assign mismatch  = (Y !== FUNC[vec_reg]);
    assign y_unknown = $isunknown(Y);
`else
    // An x/z on Y makes this comparison unknown, which the if() below treats as no error.
    assign mismatch  = (Y != FUNC[vec_reg]);
    assign y_unknown = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            pass_reg  <= '0;
            vec_reg   <= '0;
            err_reg   <= '0;
            fail_reg  <= 1'b0;
            fvec_reg  <= '0;
            xz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            pass_reg  <= pass_next;
            vec_reg   <= vec_next;
            err_reg   <= err_next;
            fail_reg  <= fail_next;
            fvec_reg  <= fvec_next;
            xz_reg    <= xz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        pass_next  = pass_reg;
        vec_next   = vec_reg;
        err_next   = err_reg;
        fail_next  = fail_reg;
        fvec_next  = fvec_reg;
        xz_next    = xz_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_next = ST_RUN;
                    step_next  = '0;
                    pass_next  = '0;
                    vec_next   = '0;
                    err_next   = '0;
                    fail_next  = 1'b0;
                    fvec_next  = '0;
                    xz_next    = 1'b0;
                end
            end
            ST_RUN: begin
                step_next = step_reg + 1'b1;
                if (step_reg == SAMPLE_STEP) begin
                    if (y_unknown) begin
                        xz_next = 1'b1;
                    end
                    if (mismatch) begin
                        err_next = (err_reg == '1) ? err_reg : err_reg + 1'b1;
                        if (!fail_reg) begin
                            fail_next = 1'b1;
                            fvec_next = vec_reg;
                        end
                    end
                end
                if (step_reg == STEP_LAST) begin
                    step_next = '0;
                    // The last vector stays on A/B after the run ends.
                    if (vec_reg == 2'd3 && pass_reg == PASS_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        vec_next = vec_reg + 1'b1;
                        if (vec_reg == 2'd3) begin
                            pass_next = pass_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign A             = vec_reg[0];
    assign B             = vec_reg[1];
    assign BUSY          = (state_reg == ST_RUN);
    assign DONE          = (state_reg == ST_DONE);
    assign FAIL          = fail_reg;
    assign ERR_CNT       = err_reg;
    assign FIRST_ERR_VEC = fvec_reg;
    assign XZ_SEEN       = xz_reg;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: two checker instances (1 pass / 8-bit count, 2 passes / 3-bit count) share START/RSTN.
// Expected run results come from a truth-table model; a negedge monitor compares when runs end.
module tb_gate_response_checker;

    localparam int         DIV    = 4;
    localparam int         SETTLE = 2;
    localparam logic [3:0] FUNC   = 4'b0001;
    localparam int         ERRW_B = 3;

    typedef struct {
        int         id;
        int         start;
        int         len;
        int         err;
        bit         fail;
        logic [1:0] fvec;
        bit         xz;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic START = 1'b0;
    logic [3:0] tt = 4'b0001;
    logic zv1 = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int busy_until[2] = '{-100, -100};
    int np_of[2] = '{1, 2};
    int errw_of[2] = '{8, ERRW_B};

    logic a_a, b_a, busy_a, done_a, fail_a, xz_a;
    logic [7:0] err_a;
    logic [1:0] fvec_a;
    logic a_b, b_b, busy_b, done_b, fail_b, xz_b;
    logic [ERRW_B-1:0] err_b;
    logic [1:0] fvec_b;
    wire y_a;
    wire y_b;

    // Gate under test: truth table tt, optionally floating at {B,A}=01.
    assign y_a = (zv1 && {b_a, a_a} == 2'b01) ? 1'bz : tt[{b_a, a_a}];
    assign y_b = (zv1 && {b_b, a_b} == 2'b01) ? 1'bz : tt[{b_b, a_b}];

    gate_response_checker #(.DIV(DIV), .SETTLE(SETTLE), .FUNC(FUNC), .NUM_PASSES(1), .ERR_W(8)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .START(START), .Y(y_a), .A(a_a), .B(b_a), .BUSY(busy_a),
        .DONE(done_a), .FAIL(fail_a), .ERR_CNT(err_a), .FIRST_ERR_VEC(fvec_a), .XZ_SEEN(xz_a));

    gate_response_checker #(.DIV(DIV), .SETTLE(SETTLE), .FUNC(FUNC), .NUM_PASSES(2), .ERR_W(ERRW_B)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .START(START), .Y(y_b), .A(a_b), .B(b_b), .BUSY(busy_b),
        .DONE(done_b), .FAIL(fail_b), .ERR_CNT(err_b), .FIRST_ERR_VEC(fvec_b), .XZ_SEEN(xz_b));

    logic [1:0] ab_o[2];
    logic       busy_o[2], done_o[2], fail_o[2], xz_o[2];
    logic [7:0] err_o[2];
    logic [1:0] fvec_o[2];

    always_comb begin
        ab_o[0] = {b_a, a_a};  ab_o[1] = {b_b, a_b};
        busy_o[0] = busy_a;    busy_o[1] = busy_b;
        done_o[0] = done_a;    done_o[1] = done_b;
        fail_o[0] = fail_a;    fail_o[1] = fail_b;
        xz_o[0] = xz_a;        xz_o[1] = xz_b;
        err_o[0] = err_a;      err_o[1] = 8'(err_b);
        fvec_o[0] = fvec_a;    fvec_o[1] = fvec_b;
    end

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (edge %0d)", name, act, cyc);
        end
    endtask

    // Whole-run result from the truth-table rules: count mismatching samples, saturate, note the first.
    function automatic exp_t model(input int id, input int t, input logic [3:0] tab, input logic z1);
        exp_t e;
        logic [3:0] f;
        int cnt;
        int first;
        int maxv;
        bit mis;
        f = FUNC;
        cnt = 0;
        first = -1;
        e.xz = 1'b0;
        for (int p = 0; p < np_of[id]; p++) begin
            for (int v = 0; v < 4; v++) begin
                if (z1 && v == 1) begin
`ifdef XZ_CHECK_EN
                    mis = 1'b1;
                    e.xz = 1'b1;
`else
                    mis = 1'b0;
`endif
                end else begin
                    mis = (tab[v] != f[v]);
                end
                if (mis) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
        end
        maxv = (1 << errw_of[id]) - 1;
        e.id = id;
        e.start = t;
        e.len = 4 * np_of[id] * DIV;
        e.err = (cnt > maxv) ? maxv : cnt;
        e.fail = (cnt > 0);
        e.fvec = (first < 0) ? 2'b00 : 2'(first);
        return e;
    endfunction

    // Called at a negedge; START is seen on the next rising edge.
    task automatic issue_start();
        int t;
        START = 1'b1;
        t = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (t > busy_until[i]) begin
                sb.push_back(model(i, t, tt, zv1));
                busy_until[i] = t + 4 * np_of[i] * DIV;
            end
        end
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle();
        int m;
        m = (busy_until[0] > busy_until[1]) ? busy_until[0] : busy_until[1];
        while (cyc <= m) @(negedge CLK);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d ab", tag, i), 32'(ab_o[i]), 32'd0);
            chk($sformatf("%s dut%0d busy", tag, i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("%s dut%0d done", tag, i), 32'(done_o[i]), 32'd0);
            chk($sformatf("%s dut%0d fail", tag, i), 32'(fail_o[i]), 32'd0);
            chk($sformatf("%s dut%0d err", tag, i), 32'(err_o[i]), 32'd0);
            chk($sformatf("%s dut%0d fvec", tag, i), 32'(fvec_o[i]), 32'd0);
            chk($sformatf("%s dut%0d xz", tag, i), 32'(xz_o[i]), 32'd0);
        end
    endtask

    // Monitor: spot-check the stimulus once per vector, then compare results on the DONE edge.
    always @(negedge CLK) begin
        if (RSTN) begin
            for (int i = 0; i < 2; i++) begin
                int k;
                int j;
                k = -1;
                for (int m = 0; m < sb.size(); m++) begin
                    if (k < 0 && sb[m].id == i) k = m;
                end
                if (k >= 0) begin
                    j = cyc - sb[k].start;
                    if (j >= 0 && j < sb[k].len && (j % DIV) == SETTLE) begin
                        chk($sformatf("dut%0d ab step %0d", i, j), 32'(ab_o[i]), 32'((j / DIV) % 4));
                        chk($sformatf("dut%0d busy step %0d", i, j), 32'(busy_o[i]), 32'd1);
                    end else if (j == sb[k].len) begin
                        chk($sformatf("dut%0d done", i), 32'(done_o[i]), 32'd1);
                        chk($sformatf("dut%0d busy end", i), 32'(busy_o[i]), 32'd0);
                        chk($sformatf("dut%0d err_cnt", i), 32'(err_o[i]), 32'(sb[k].err));
                        chk($sformatf("dut%0d fail", i), 32'(fail_o[i]), 32'(sb[k].fail));
                        chk($sformatf("dut%0d first_err_vec", i), 32'(fvec_o[i]), 32'(sb[k].fvec));
                        chk($sformatf("dut%0d xz_seen", i), 32'(xz_o[i]), 32'(sb[k].xz));
                        chk($sformatf("dut%0d ab end", i), 32'(ab_o[i]), 32'd3);
                        sb.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        repeat (3) @(negedge CLK);
        check_reset("reset");
        RSTN = 1'b1;
        @(negedge CLK);

        tt = 4'b0001; issue_start(); wait_idle();   // matching NOR
        tt = 4'b0000; issue_start(); wait_idle();   // stuck at 0
        tt = 4'b1110; issue_start(); wait_idle();   // OR: dut_b saturates

        // Reset during vector 2 aborts both runs at once.
        tt = 4'b0001;
        t0 = cyc + 1;
        issue_start();
        while (cyc < t0 + 2 * DIV + 1) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check_reset("async reset");
        sb.delete();
        busy_until[0] = -100;
        busy_until[1] = -100;
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post-reset dut0 busy", 32'(busy_a), 32'd0);
        chk("post-reset dut1 done", 32'(done_b), 32'd0);
        issue_start(); wait_idle();

        // START mid-run, START on a final edge, START in DONE.
        tt = 4'b1001;
        issue_start();
        repeat (6) @(negedge CLK);
        issue_start();
        while (cyc < busy_until[0] - 1) @(negedge CLK);
        issue_start();
        wait_idle();
        tt = 4'b0001;
        issue_start();
        while (cyc < busy_until[1] - 1) @(negedge CLK);
        issue_start();
        wait_idle();

        // Floating Y on vector 1.
        tt = 4'b0001; zv1 = 1'b1; issue_start(); wait_idle(); zv1 = 1'b0;

        for (int r = 0; r < 10; r++) begin
            tt = 4'($urandom_range(0, 15));
            zv1 = ($urandom_range(0, 3) == 0);
            issue_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(negedge CLK);
                issue_start();
            end
            wait_idle();
            zv1 = 1'b0;
        end

        repeat (2) @(negedge CLK);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
